// File: rtl/reg_window_pkg.sv
// Shared types and constants for the SPARC register-window controller.
package reg_window_pkg;

    localparam int unsigned NumWin = 4;
    localparam logic [4:0] LocalBase = 5'd16;  // r16: first local register of a window
    localparam logic [NumWin-1:0] WimRst = 4'b0010;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StSpill,
        StFill,
        StFinish
    } win_state_e;

    function automatic logic [NumWin-1:0] win_onehot(input logic [1:0] w);
        return 4'b0001 << w;
    endfunction

endpackage

// File: rtl/reg_window_ctrl_if.sv
// Data-memory port used by the window controller for spill/fill traffic.
interface reg_window_ctrl_if #(
    parameter int unsigned AW = 10
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/reg_window_ctrl_win_xfer_seq.sv
// 16-word transfer sequencer shared by spill and fill: word counter,
// request/write strobes and stack address {ptr, idx}.
module win_xfer_seq #(
    parameter int unsigned PTR_W = 4,
    parameter int unsigned AW    = 10
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             run,
    input  logic             write,
    input  logic [PTR_W-1:0] ptr,
    input  logic             ack,
    output logic [3:0]       idx,
    output logic             last,
    output logic             req,
    output logic             we,
    output logic [AW-1:0]    addr
);

    logic [3:0] idx_q;

    // Word counter; restarts at 0 whenever no transfer is running.
    always_ff @(posedge Clk) begin
        if (Reset || !run) begin
            idx_q <= '0;
        end else if (ack) begin
            idx_q <= idx_q + 4'd1;
        end
    end

    assign idx  = idx_q;
    assign req  = run;
    assign we   = run & write;
    assign last = run & ack & (idx_q == 4'hF);

    // Zero-extended {ptr, idx} address, forced to 0 while idle.
    always_comb begin
        addr = '0;
        if (run) begin
            addr[PTR_W+3:0] = {ptr, idx_q};
        end
    end

endmodule

// File: rtl/reg_window_ctrl.sv
// SPARC 4-window register window manager: owns CWP/WIM, serves SAVE/RESTORE,
// spills/fills r16..r31 to a memory stack on overflow/underflow.
// Optional macro WIN_STATS_EN adds saturating spill/fill completion counters.
module reg_window_ctrl
    import reg_window_pkg::*;
#(
    parameter int unsigned NWIN  = NumWin,
    parameter int unsigned PTR_W = 4,
    parameter int unsigned AW    = 10
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            save_req,
    input  logic            restore_req,
    input  logic            wim_we,
    input  logic [NWIN-1:0] wim_in,
    output logic            done,
    output logic            trap,
    output logic            busy,
    output logic [1:0]      cwp,
    output logic [NWIN-1:0] wim,
    output logic [1:0]      rf_cwp,
    output logic [4:0]      rf_ra,
    output logic [4:0]      rf_rc,
    output logic            rf_rfe,
    output logic [31:0]     rf_rin,
    input  logic [31:0]     rf_aout,
    reg_window_ctrl_if.master mem
`ifdef WIN_STATS_EN
    ,
    output logic [15:0]     spill_cnt,
    output logic [15:0]     fill_cnt
`endif
);

    win_state_e      state_q;
    logic [1:0]      cwp_q;
    logic [1:0]      tgt_q;  // window being spilled (S) or filled (F)
    logic [NWIN-1:0] wim_q;
    logic [PTR_W-1:0] ptr_q;
    logic            is_save_q;
    logic            done_q;
    logic            trap_q;
    logic            busy_q;

    logic [1:0]    save_n;
    logic [1:0]    rest_n;
    logic          xfer_run;
    logic          xfer_write;
    logic          xfer_last;
    logic [3:0]    xfer_idx;
    logic          xfer_req;
    logic          xfer_we;
    logic [AW-1:0] xfer_addr;

    assign save_n     = cwp_q - 2'd1;
    assign rest_n     = cwp_q + 2'd1;
    assign xfer_run   = (state_q == StSpill) || (state_q == StFill);
    assign xfer_write = (state_q == StSpill);

    win_xfer_seq #(
        .PTR_W(PTR_W),
        .AW   (AW)
    ) u_xfer (
        .Clk  (Clk),
        .Reset(Reset),
        .run  (xfer_run),
        .write(xfer_write),
        .ptr  (ptr_q),
        .ack  (mem.mem_ack),
        .idx  (xfer_idx),
        .last (xfer_last),
        .req  (xfer_req),
        .we   (xfer_we),
        .addr (xfer_addr)
    );

    // Main FSM: window bookkeeping plus registered done/trap/busy.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= StIdle;
            cwp_q     <= '0;
            tgt_q     <= '0;
            wim_q     <= WimRst;
            ptr_q     <= '0;
            is_save_q <= 1'b0;
            done_q    <= 1'b0;
            trap_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            trap_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (wim_we) begin
                        wim_q <= wim_in;
                    end
                    // SAVE wins; a concurrent RESTORE simply stays pending.
                    if (save_req || restore_req) begin
                        is_save_q <= save_req;
                        state_q   <= StCheck;
                        busy_q    <= 1'b1;
                    end
                end
                StCheck: begin
                    if (is_save_q) begin
                        if (!wim_q[save_n]) begin
                            cwp_q   <= save_n;
                            done_q  <= 1'b1;
                            state_q <= StFinish;
                        end else if (ptr_q == {PTR_W{1'b1}}) begin
                            trap_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            tgt_q   <= save_n - 2'd1;
                            state_q <= StSpill;
                        end
                    end else begin
                        if (!wim_q[rest_n]) begin
                            cwp_q   <= rest_n;
                            done_q  <= 1'b1;
                            state_q <= StFinish;
                        end else if (ptr_q == '0) begin
                            trap_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StIdle;
                        end else begin
                            ptr_q   <= ptr_q - 1'b1;
                            tgt_q   <= rest_n;
                            state_q <= StFill;
                        end
                    end
                end
                StSpill: begin
                    if (xfer_last) begin
                        ptr_q   <= ptr_q + 1'b1;
                        wim_q   <= win_onehot(tgt_q);
                        cwp_q   <= save_n;
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end
                end
                StFill: begin
                    if (xfer_last) begin
                        wim_q   <= win_onehot(tgt_q + 2'd1);
                        cwp_q   <= tgt_q;
                        done_q  <= 1'b1;
                        state_q <= StFinish;
                    end
                end
                StFinish: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Register-file steering: the controller only borrows the file during spill/fill.
    always_comb begin
        rf_cwp         = cwp_q;
        rf_ra          = '0;
        rf_rc          = '0;
        rf_rfe         = 1'b1;
        rf_rin         = '0;
        mem.mem_wdata  = '0;
        case (state_q)
            StSpill: begin
                rf_cwp        = tgt_q;
                rf_ra         = LocalBase + {1'b0, xfer_idx};
                mem.mem_wdata = rf_aout;
            end
            StFill: begin
                rf_cwp = tgt_q;
                rf_rc  = LocalBase + {1'b0, xfer_idx};
                if (mem.mem_ack) begin
                    rf_rfe = 1'b0;
                    rf_rin = mem.mem_rdata;
                end
            end
            default: ;
        endcase
    end

    assign mem.mem_req  = xfer_req;
    assign mem.mem_we   = xfer_we;
    assign mem.mem_addr = xfer_addr;

    assign done = done_q;
    assign trap = trap_q;
    assign busy = busy_q;
    assign cwp  = cwp_q;
    assign wim  = wim_q;

`ifdef WIN_STATS_EN
    logic [15:0] spill_cnt_q;
    logic [15:0] fill_cnt_q;

    // Saturating completion counters.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            spill_cnt_q <= '0;
            fill_cnt_q  <= '0;
        end else if (xfer_last) begin
            if (state_q == StSpill && spill_cnt_q != 16'hFFFF) begin
                spill_cnt_q <= spill_cnt_q + 16'd1;
            end
            if (state_q == StFill && fill_cnt_q != 16'hFFFF) begin
                fill_cnt_q <= fill_cnt_q + 16'd1;
            end
        end
    end

    assign spill_cnt = spill_cnt_q;
    assign fill_cnt  = fill_cnt_q;
`endif

endmodule

// File: doc/reg_window_ctrl.md
Name: reg_window_ctrl

Overview:
- Window manager for the 4-window SPARC register file (2-bit CWP, RA/RB/RC, active-low RFE write enable, Rin write data).
- Owns CWP and WIM and accepts SAVE/RESTORE requests from the decode stage.
- On window overflow, spills registers r16..r31 of a window to memory with hardware sequencing. On underflow, fills them back the same way.
- Sits between decode, the register file and the data-memory port; multiplexes the file's CWP/RA/RC/RFE during spill/fill.

Parameters:
- NWIN, 4, number of windows; must match the 2-bit CWP.
- PTR_W, 4, width of the spill-stack pointer; stack depth = 2**PTR_W windows.
- AW, 10, memory word-address width; must be >= PTR_W+4.

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- save_req  in  1  SAVE request, held until done
- restore_req  in  1  RESTORE request, held until done
- wim_we  in  1  load WIM from wim_in (WRWIM)
- wim_in  in  4  new WIM value
- done  out  1  one-cycle pulse: request completed
- trap  out  1  one-cycle pulse: stack overflow/underflow, request aborted
- busy  out  1  high while not IDLE
- cwp  out  2  current window pointer
- wim  out  4  window invalid mask
- rf_cwp  out  2  CWP driven to the register file
- rf_ra  out  5  register file read address A
- rf_rc  out  5  register file write address
- rf_rfe  out  1  register file write enable, active low
- rf_rin  out  32  register file write data
- rf_aout  in  32  register file read data A
- mem_req  out  1  memory request
- mem_we  out  1  1 = write, 0 = read
- mem_addr  out  AW  word address
- mem_wdata  out  32  write data
- mem_ack  in  1  request accepted; read data valid this cycle
- mem_rdata  in  32  read data

Behaviour:
- Reset values: cwp=0, wim=4'b0010, ptr=0, state IDLE, done=0, trap=0, busy=0, mem_req=0, mem_we=0, rf_rfe=1, rf_ra=0, rf_rc=0, rf_rin=0, mem_addr=0, mem_wdata=0. Reset mid-spill/fill aborts the operation and issues no done.
- Outside SPILL/FILL: rf_cwp=cwp, rf_rfe=1 (the controller never writes the file), rf_ra=0, rf_rc=0.
- FSM states: IDLE, CHECK, SPILL, FILL, FINISH.
- IDLE:
  - wim_we loads wim (IDLE only; ignored while busy).
  - save_req has priority over restore_req; either moves to CHECK.
- CHECK:
  - SAVE: n=(cwp-1) mod NWIN.
    - wim[n]=0 -> cwp<=n, go FINISH.
    - wim[n]=1, ptr=2**PTR_W-1 -> trap pulse, go IDLE; cwp/wim unchanged.
    - Otherwise go SPILL with target S=(n-1) mod NWIN and i=0.
  - RESTORE: n=(cwp+1) mod NWIN.
    - wim[n]=0 -> cwp<=n, go FINISH.
    - wim[n]=1, ptr=0 -> trap pulse, go IDLE.
    - Otherwise ptr<=ptr-1, go FILL with target F=n and i=0.
- SPILL:
  - Drive rf_cwp=S, rf_ra=16+i, mem_req=1, mem_we=1, mem_addr={ptr,i[3:0]} zero-extended, mem_wdata=rf_aout (combinational read).
  - On mem_ack: i++.
  - On ack with i=15: ptr++, wim<=one-hot(S), cwp<=n, go FINISH.
  - Without ack, all outputs hold stable.
- FILL:
  - Drive rf_cwp=F, mem_req=1, mem_we=0, mem_addr={ptr,i}.
  - On mem_ack: rf_rc=16+i, rf_rin=mem_rdata, rf_rfe=0 that same cycle (written on that Clk edge), i++.
  - On ack with i=15: wim<=one-hot((F+1) mod NWIN), cwp<=F, go FINISH.
- FINISH: done pulse for 1 cycle, go IDLE.
- Latency: no spill/fill = 2 cycles from request to done. Spill/fill = 2 + (sum of cycles to each of 16 acks).
- save_req and restore_req both high: SAVE served; restore_req stays pending.

Optional Feature:
- Macro WIN_STATS_EN.
- Defined:
  - Adds outputs spill_cnt[15:0] and fill_cnt[15:0], both reset to 0.
  - Each increments on completion of a spill/fill; saturates at 16'hFFFF.
- Undefined: the ports and counters are absent.
- Core behaviour is identical either way.

Decomposition:
- Package reg_window_pkg holds:
  - state enum (IDLE, CHECK, SPILL, FILL, FINISH);
  - NWIN and the local/in base constant (16);
  - WIM reset value 4'b0010.
- One natural sub-module, win_xfer_seq: the 16-word transfer counter, mem handshake and address build, shared by SPILL and FILL.

Test Plan:
- Reset, then SAVE with wim=0010 -> CHECK finds wim[3]=0 -> cwp=3, done at cycle 2, no mem_req.
- cwp=2, wim=0010, SAVE, ack every cycle:
  - 16 writes at addr 0..15 from window 0 r16..r31;
  - then wim=0001, cwp=1, ptr=1, done.
- After that spill, RESTORE repeatedly until wim hit:
  - fill of window F at addr 0..15;
  - rf_rfe=0 on each ack with rf_rc=16..31;
  - ptr=0, wim rotates to F+1.
- RESTORE underflow with ptr=0 -> trap pulse, cwp/wim unchanged, no mem_req.
- Spill with mem_ack asserted every 3rd cycle -> addresses and wdata hold stable between acks, 16 writes total.
- Reset asserted at word 7 of a spill -> next cycle IDLE, mem_req=0, cwp=0, wim=0010, no done.
